// File: rtl/nrzi_rx_deserializer.sv
// NRZI receive decoder with bit-unstuffing, SE0 end-of-packet detection and LSB-first word assembly.
// Optional SYNC hunting before data assembly is enabled by defining NRZI_SYNC_DETECT_EN.
module nrzi_rx_deserializer #(
    parameter int   WORD_W      = 8,
    parameter int   STUFF_LIMIT = 6,
    parameter logic IDLE_LEVEL  = 1'b1
) (
    input  logic              clk,
    input  logic              RST,
    input  logic              bit_strobe,
    input  logic              start_decoding,
    input  logic              curr_bit,
    input  logic              se0,
    output logic [WORD_W-1:0] word_out,
    output logic              word_valid,
    output logic              eop,
    output logic              align_err,
    output logic              stuff_err,
    output logic              sync_found
);

    localparam int ONES_W = $clog2(STUFF_LIMIT + 1);
    localparam int BIT_W  = $clog2(WORD_W);

`ifdef NRZI_SYNC_DETECT_EN
    typedef enum logic [1:0] {IDLE, ACTIVE, ERROR, HUNT} state_t;
    localparam state_t AFTER_EOP = HUNT;
`else
    typedef enum logic [1:0] {IDLE, ACTIVE, ERROR} state_t;
    localparam state_t AFTER_EOP = ACTIVE;
`endif

    state_t              state_reg, state_next;
    logic                prev_bit_reg;
    logic [ONES_W-1:0]   ones_cnt_reg, ones_cnt_next;
    logic [BIT_W-1:0]    bit_cnt_reg, bit_cnt_next;
    logic [WORD_W-1:0]   shift_reg, shift_next;
    logic [WORD_W-1:0]   shift_ins;
    logic [WORD_W-1:0]   word_out_reg, word_out_next;
    logic                word_valid_reg, word_valid_next;
    logic                eop_reg, eop_next;
    logic                align_err_reg, align_err_next;
    logic                stuff_err_reg, stuff_err_next;
    logic                decoded;

    assign decoded = (curr_bit == prev_bit_reg);

    // Partial word with the current decoded bit dropped into slot bit_cnt.
    generate
        for (genvar gi = 0; gi < WORD_W; gi++) begin : g_ins
            assign shift_ins[gi] = (bit_cnt_reg == BIT_W'(gi)) ? decoded : shift_reg[gi];
        end
    endgenerate

`ifdef NRZI_SYNC_DETECT_EN
    logic [7:0] hist_reg, hist_next;
    logic [7:0] hist_shift;
    logic       sync_found_reg, sync_found_next;

    assign hist_shift = {hist_reg[6:0], decoded};
    assign sync_found = sync_found_reg;
`else
    assign sync_found = 1'b0;
`endif

    always_comb begin
        state_next      = state_reg;
        ones_cnt_next   = ones_cnt_reg;
        bit_cnt_next    = bit_cnt_reg;
        shift_next      = shift_reg;
        word_out_next   = word_out_reg;
        word_valid_next = 1'b0;
        eop_next        = 1'b0;
        align_err_next  = 1'b0;
        stuff_err_next  = 1'b0;
`ifdef NRZI_SYNC_DETECT_EN
        hist_next       = hist_reg;
        sync_found_next = 1'b0;
`endif
        if (!start_decoding) begin
            state_next    = IDLE;
            ones_cnt_next = '0;
            bit_cnt_next  = '0;
        end else begin
            case (state_reg)
                IDLE: begin
                    state_next    = AFTER_EOP;
                    ones_cnt_next = '0;
                    bit_cnt_next  = '0;
`ifdef NRZI_SYNC_DETECT_EN
                    hist_next     = '1;
`endif
                end
`ifdef NRZI_SYNC_DETECT_EN
                HUNT: begin
                    if (bit_strobe) begin
                        hist_next = hist_shift;
                        if (hist_shift == 8'h01) begin
                            sync_found_next = 1'b1;
                            ones_cnt_next   = ONES_W'(1);
                            bit_cnt_next    = '0;
                            state_next      = ACTIVE;
                        end
                    end
                end
`endif
                ACTIVE: begin
                    if (bit_strobe) begin
                        if (se0) begin
                            eop_next       = 1'b1;
                            align_err_next = (bit_cnt_reg != '0);
                            ones_cnt_next  = '0;
                            bit_cnt_next   = '0;
                            state_next     = AFTER_EOP;
`ifdef NRZI_SYNC_DETECT_EN
                            hist_next      = '1;
`endif
                        end else if (ones_cnt_reg == ONES_W'(STUFF_LIMIT)) begin
                            // This bit must be the stuffed 0; a 1 here is a violation.
                            ones_cnt_next = '0;
                            if (decoded) begin
                                stuff_err_next = 1'b1;
                                bit_cnt_next   = '0;
                                state_next     = ERROR;
                            end
                        end else begin
                            shift_next    = shift_ins;
                            ones_cnt_next = decoded ? ones_cnt_reg + 1'b1 : '0;
                            if (bit_cnt_reg == BIT_W'(WORD_W - 1)) begin
                                word_out_next   = shift_ins;
                                word_valid_next = 1'b1;
                                bit_cnt_next    = '0;
                            end else begin
                                bit_cnt_next = bit_cnt_reg + 1'b1;
                            end
                        end
                    end
                end
                ERROR: begin
                    if (bit_strobe && se0) begin
                        eop_next      = 1'b1;
                        ones_cnt_next = '0;
                        bit_cnt_next  = '0;
                        state_next    = AFTER_EOP;
`ifdef NRZI_SYNC_DETECT_EN
                        hist_next     = '1;
`endif
                    end
                end
                default: state_next = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (RST) begin
            state_reg      <= IDLE;
            prev_bit_reg   <= IDLE_LEVEL;
            ones_cnt_reg   <= '0;
            bit_cnt_reg    <= '0;
            shift_reg      <= '0;
            word_out_reg   <= '0;
            word_valid_reg <= 1'b0;
            eop_reg        <= 1'b0;
            align_err_reg  <= 1'b0;
            stuff_err_reg  <= 1'b0;
`ifdef NRZI_SYNC_DETECT_EN
            hist_reg       <= '1;
            sync_found_reg <= 1'b0;
`endif
        end else begin
            state_reg      <= state_next;
            // The line level is tracked on every strobe so the first active bit decodes correctly.
            if (bit_strobe) begin
                prev_bit_reg <= curr_bit;
            end
            ones_cnt_reg   <= ones_cnt_next;
            bit_cnt_reg    <= bit_cnt_next;
            shift_reg      <= shift_next;
            word_out_reg   <= word_out_next;
            word_valid_reg <= word_valid_next;
            eop_reg        <= eop_next;
            align_err_reg  <= align_err_next;
            stuff_err_reg  <= stuff_err_next;
`ifdef NRZI_SYNC_DETECT_EN
            hist_reg       <= hist_next;
            sync_found_reg <= sync_found_next;
`endif
        end
    end

    assign word_out   = word_out_reg;
    assign word_valid = word_valid_reg;
    assign eop        = eop_reg;
    assign align_err  = align_err_reg;
    assign stuff_err  = stuff_err_reg;

endmodule

// File: tb/tb_nrzi_rx_deserializer.sv
// Directed bench for nrzi_rx_deserializer: queue-based behavioural model checked every cycle,
// plus literal expectations at the key points of each scenario.
module tb_nrzi_rx_deserializer;

`ifdef NRZI_SYNC_DETECT_EN
    localparam int SYNC_EN = 1;
`else
    localparam int SYNC_EN = 0;
`endif
    localparam int LIMIT = 6;

    logic       clk = 1'b0;
    logic       RST, bit_strobe, start_decoding, curr_bit, se0;
    logic [7:0] word_out;
    logic       word_valid, eop, align_err, stuff_err, sync_found;

    always #5 clk = ~clk;

    nrzi_rx_deserializer dut (
        .clk(clk), .RST(RST), .bit_strobe(bit_strobe), .start_decoding(start_decoding),
        .curr_bit(curr_bit), .se0(se0), .word_out(word_out), .word_valid(word_valid),
        .eop(eop), .align_err(align_err), .stuff_err(stuff_err), .sync_found(sync_found)
    );

    int   checks = 0;
    int   errors = 0;
    logic rst, st, line;

    // Model: mode 0 idle, 1 active, 2 error, 3 hunt
    int   m_mode;
    logic m_prev;
    int   m_ones;
    bit   m_bits[$];
    logic [7:0] m_hist;
    logic [7:0] e_word;
    logic e_valid, e_eop, e_align, e_stuff, e_sync;
    bit   have_exp = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h t=%0t", name, act, req, $time);
        end
    endtask

    task automatic model_step(input logic stb, input logic c, input logic s);
        logic dec;
        if (rst) begin
            m_mode = 0; m_prev = 1'b1; m_ones = 0; m_bits.delete(); m_hist = '1;
            e_word = 0; e_valid = 0; e_eop = 0; e_align = 0; e_stuff = 0; e_sync = 0;
            return;
        end
        e_valid = 0; e_eop = 0; e_align = 0; e_stuff = 0; e_sync = 0;
        dec = (c == m_prev);
        if (stb) m_prev = c;
        if (!st) begin
            m_mode = 0; m_ones = 0; m_bits.delete();
            return;
        end
        case (m_mode)
            0: begin
                m_mode = SYNC_EN ? 3 : 1; m_ones = 0; m_bits.delete(); m_hist = '1;
            end
            3: if (stb) begin
                m_hist = {m_hist[6:0], dec};
                if (m_hist == 8'h01) begin
                    e_sync = 1; m_ones = 1; m_bits.delete(); m_mode = 1;
                end
            end
            1: if (stb) begin
                if (s) begin
                    e_eop = 1; e_align = (m_bits.size() != 0);
                    m_bits.delete(); m_ones = 0; m_hist = '1; m_mode = SYNC_EN ? 3 : 1;
                end else if (m_ones == LIMIT) begin
                    m_ones = 0;
                    if (dec) begin
                        e_stuff = 1; m_bits.delete(); m_mode = 2;
                    end
                end else begin
                    m_bits.push_back(dec);
                    m_ones = dec ? m_ones + 1 : 0;
                    if (m_bits.size() == 8) begin
                        for (int i = 0; i < 8; i++) e_word[i] = m_bits[i];
                        e_valid = 1;
                        m_bits.delete();
                    end
                end
            end
            2: if (stb && s) begin
                e_eop = 1; m_bits.delete(); m_ones = 0; m_hist = '1; m_mode = SYNC_EN ? 3 : 1;
            end
            default: m_mode = 0;
        endcase
    endtask

    // Called at a falling edge: check the previous cycle's outputs, then drive and predict the next.
    task automatic cycle(input logic stb, input logic c, input logic s);
        if (have_exp)
            chk("cycle", {word_out, word_valid, eop, align_err, stuff_err, sync_found},
                {e_word, e_valid, e_eop, e_align, e_stuff, e_sync});
        bit_strobe = stb; curr_bit = c; se0 = s; RST = rst; start_decoding = st;
        model_step(stb, c, s);
        have_exp = 1;
        @(negedge clk);
    endtask

    task automatic send_dec(input logic d);
        cycle(1'b0, line, 1'b0);
        if (!d) line = ~line;
        cycle(1'b1, line, 1'b0);
    endtask

    task automatic send_se0();
        cycle(1'b0, line, 1'b0);
        cycle(1'b1, line, 1'b1);
    endtask

    task automatic send_bits(input logic [15:0] b, input int n);
        for (int i = 0; i < n; i++) send_dec(b[i]);
    endtask

    initial begin
        rst = 1; st = 0; line = 1;
        RST = 1; bit_strobe = 0; start_decoding = 0; curr_bit = 1; se0 = 0;
        @(negedge clk);
        cycle(1'b0, line, 1'b0);
        cycle(1'b0, line, 1'b0);
        chk("reset_outputs", {word_out, word_valid, eop, align_err, stuff_err, sync_found}, 0);
        rst = 0;
        cycle(1'b0, line, 1'b0);

        // Toggling line decodes to zeros
        st = 1;
        cycle(1'b0, line, 1'b0);
        for (int i = 0; i < 8; i++) begin
            cycle(1'b0, line, 1'b0);
            line = ~line;
            cycle(1'b1, line, 1'b0);
            if (i < 7) chk("t1_no_early_valid", word_valid, 0);
        end
        chk("t1_valid", word_valid, 1);
        chk("t1_word", word_out, 8'h00);

        // Six ones, stuffed zero dropped, two more ones
        send_bits(16'b1_1011_1111, 9);
        chk("t2_valid", word_valid, 1);
        chk("t2_word", word_out, 8'hFF);

        // Stuff violation then EOP from ERROR
        send_se0();
        send_bits(16'h007F, 7);
        chk("t3_stuff_err", {stuff_err, word_valid}, 2'b10);
        send_se0();
        chk("t3_eop", {eop, align_err}, 2'b10);
        send_bits(16'h003C, 8);
        chk("t3_word", {word_valid, word_out}, {1'b1, 8'h3C});

        // Aligned and misaligned EOP
        send_se0();
        chk("t4_eop_aligned", {eop, align_err}, 2'b10);
        send_bits(16'h0555, 8);
        chk("t4_word", word_out, 8'h55);
        send_bits(16'h0005, 3);
        send_se0();
        chk("t4_eop_misaligned", {eop, align_err}, 2'b11);

        // Reset mid-word
        send_bits(16'h001F, 5);
        rst = 1;
        cycle(1'b0, line, 1'b0);
        chk("t5_reset_outputs", {word_out, word_valid, eop, align_err, stuff_err, sync_found}, 0);
        rst = 0; line = 1;
        send_bits(16'h0096, 8);
        chk("t5_word", {word_valid, word_out}, {1'b1, 8'h96});

        // start_decoding dropped mid-word
        send_bits(16'h000A, 4);
        st = 0;
        cycle(1'b0, line, 1'b0);
        send_se0();
        chk("t5_no_eop_idle", {eop, word_valid}, 2'b00);
        st = 1;
        cycle(1'b0, line, 1'b0);

        // Garbage, SYNC, then 0xA5
        send_bits(16'b011, 3);
        send_bits(16'b1000_0000, 8);
        chk("t6_sync", sync_found, SYNC_EN[0]);
        send_bits(16'h00A5, 8);
        if (SYNC_EN != 0) chk("t6_word", {word_valid, word_out}, {1'b1, 8'hA5});
        else chk("t6_sync_quiet", sync_found, 0);
        send_se0();
        cycle(1'b0, line, 1'b0);
        cycle(1'b0, line, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
